// File: rtl/decode_fwd_hazard_pkg.sv
// Shared types and sizing helpers for the decode/execute operand-resolution stage.
package decode_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREGS  = 8;

  // Register-index width; never narrower than one bit.
  function automatic int reg_w_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {EMPTY, FULL} oreg_state_e;

endpackage

// File: rtl/decode_fwd_hazard_fwd_select.sv
// Per-port operand mux: the youngest matching forwarding tap wins, else register file.
module fwd_select #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int NFWD   = 3
) (
  input  logic [REG_W-1:0]             i_src_sel,
  input  logic [DATA_W-1:0]            i_rf_rdata,
  input  logic [NFWD-1:0]              i_fwd_valid,
  input  logic [NFWD-1:0][REG_W-1:0]   i_fwd_sel,
  input  logic [NFWD-1:0][DATA_W-1:0]  i_fwd_data,
  output logic [DATA_W-1:0]            o_data
);

  // Walk oldest to youngest so the lowest matching index is written last.
  always_comb begin
    o_data = i_rf_rdata;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (i_fwd_valid[k] && (i_fwd_sel[k] == i_src_sel)) o_data = i_fwd_data[k];
    end
  end

endmodule

// File: rtl/decode_fwd_hazard.sv
// Decode-to-execute stage: operand forwarding, load-use stall, valid/ready output register.
module decode_fwd_hazard
  import decode_pkg::*;
#(
  parameter int   DATA_W   = DEF_DATA_W,
  parameter int   NREGS    = DEF_NREGS,
  parameter int   NPORTS   = 2,
  parameter int   NFWD     = 3,
  parameter int   LOAD_LAT = 1,
  parameter int   CNT_W    = 16,
  localparam int  REG_W    = reg_w_of(NREGS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NPORTS-1:0][REG_W-1:0]     src_sel,
  input  logic [NPORTS-1:0]                src_used,
  input  logic [REG_W-1:0]                 dst_sel,
  input  logic                             dst_we,
  input  logic                             is_load,
  input  logic [NPORTS-1:0][DATA_W-1:0]    rf_rdata,
  input  logic [NFWD-1:0]                  fwd_valid,
  input  logic [NFWD-1:0][REG_W-1:0]       fwd_sel,
  input  logic [NFWD-1:0][DATA_W-1:0]      fwd_data,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NPORTS-1:0][DATA_W-1:0]    out_data,
  output logic [REG_W-1:0]                 out_dst_sel,
  output logic                             out_dst_we,
  output logic                             out_is_load,
  output logic [CNT_W-1:0]                 stall_count
);

  localparam int SH_W = reg_w_of(LOAD_LAT + 1);

  logic [NPORTS-1:0][DATA_W-1:0] w_opnd;
  logic                          w_dep;
  logic                          w_hazard;
  logic                          w_accept;
  oreg_state_e                   r_state, w_state_nxt;
  logic [SH_W-1:0]               r_shadow_cnt;
  logic [REG_W-1:0]              r_shadow_reg;
  logic [CNT_W-1:0]              r_stall_count;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W), .NFWD(NFWD)) u_sel (
      .i_src_sel   (src_sel[p]),
      .i_rf_rdata  (rf_rdata[p]),
      .i_fwd_valid (fwd_valid),
      .i_fwd_sel   (fwd_sel),
      .i_fwd_data  (fwd_data),
      .o_data      (w_opnd[p])
    );
  end

  // The shadow overrides tap matches: a pending load's tap data is not yet real.
  always_comb begin
    w_dep = 1'b0;
    for (int p = 0; p < NPORTS; p++)
      if (src_used[p] && (src_sel[p] == r_shadow_reg)) w_dep = 1'b1;
  end

  assign w_hazard  = in_valid && (r_shadow_cnt != '0) && w_dep;
  assign out_valid = (r_state == FULL);
  assign in_ready  = !flush && !w_hazard && (!out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_nxt = FULL;
      FULL:    if (w_accept) w_state_nxt = FULL;
               else if (out_ready) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) w_state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= EMPTY;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data    <= '0;
      out_dst_sel <= '0;
      out_dst_we  <= 1'b0;
      out_is_load <= 1'b0;
    end else if (w_accept) begin
      out_data    <= w_opnd;
      out_dst_sel <= dst_sel;
      out_dst_we  <= dst_we;
      out_is_load <= is_load;
    end
  end

  // Shadow ages only when execute advances, so backpressure keeps it armed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shadow_cnt <= '0;
      r_shadow_reg <= '0;
    end else if (flush) begin
      r_shadow_cnt <= '0;
    end else if (w_accept && is_load && dst_we && (LOAD_LAT > 0)) begin
      r_shadow_cnt <= SH_W'(LOAD_LAT);
      r_shadow_reg <= dst_sel;
    end else if (out_ready && (r_shadow_cnt != '0)) begin
      r_shadow_cnt <= r_shadow_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                                    r_stall_count <= '0;
    else if (w_hazard && (r_stall_count != '1))  r_stall_count <= r_stall_count + 1'b1;
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_decode_fwd_hazard.sv
// Directed bench for decode_fwd_hazard: queued expectations checked by a handshake monitor.
module tb_decode_fwd_hazard;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0][2:0]        src_sel;
  logic [1:0]             src_used;
  logic [2:0]             dst_sel;
  logic                   dst_we;
  logic                   is_load;
  logic [1:0][15:0]       rf_rdata;
  logic [2:0]             fwd_valid;
  logic [2:0][2:0]        fwd_sel;
  logic [2:0][15:0]       fwd_data;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [1:0][15:0]       out_data;
  logic [2:0]             out_dst_sel;
  logic                   out_dst_we;
  logic                   out_is_load;
  logic [3:0]             stall_count;

  typedef struct packed {
    logic [1:0][15:0] data;
    logic [2:0]       dst;
    logic             we;
    logic             ld;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  decode_fwd_hazard #(.DATA_W(16), .NREGS(8), .NPORTS(2), .NFWD(3), .LOAD_LAT(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src_sel(src_sel), .src_used(src_used), .dst_sel(dst_sel), .dst_we(dst_we),
    .is_load(is_load), .rf_rdata(rf_rdata), .fwd_valid(fwd_valid), .fwd_sel(fwd_sel),
    .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dst_sel(out_dst_sel), .out_dst_we(out_dst_we),
    .out_is_load(out_is_load), .stall_count(stall_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every output handshake consumes one queued expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {1'b1}, {1'b0});
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_fields", {25'd0, out_data, out_dst_sel, out_dst_we, out_is_load}, {25'd0, e});
      end
    end
  end

  task automatic issue(input logic [1:0][2:0] ss, input logic [1:0] su, input logic [2:0] d,
                       input logic we, input logic ld, input logic [1:0][15:0] rf,
                       input logic [1:0][15:0] exp_data, input bit push, output int waits);
    src_sel = ss; src_used = su; dst_sel = d; dst_we = we; is_load = ld; rf_rdata = rf;
    in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 30) begin
        chk("accept_timeout", {1'b0}, {1'b1});
        break;
      end
    end
    if (push) q.push_back('{data: exp_data, dst: d, we: we, ld: ld});
    @(posedge clk); #1;
    in_valid = 1'b0; src_used = 2'b00;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int w;
    logic [1:0][15:0] hold;
    rst = 1'b0; in_valid = 1'b0; src_sel = '0; src_used = '0; dst_sel = '0; dst_we = 1'b0;
    is_load = 1'b0; rf_rdata = '0; fwd_valid = '0; fwd_sel = '0; fwd_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    cycles(2);
    @(negedge clk);
    chk("reset_out_valid", {out_valid}, {1'b0});
    chk("reset_out_data", {out_data}, {32'h0});
    chk("reset_stall_count", {stall_count}, {4'd0});
    chk("reset_in_ready", {in_ready}, {1'b1});
    @(posedge clk); #1; rst = 1'b1;

    // No tap matches: register file data passes through, one-cycle latency.
    issue({3'd5, 3'd3}, 2'b11, 3'd1, 1'b1, 1'b0, {16'h2222, 16'h1111}, {16'h2222, 16'h1111}, 1, w);
    chk("latency_out_valid", {out_valid}, {1'b1});

    // Tap priority: tap0 beats tap2 on r3; tap1 supplies r5.
    fwd_valid = 3'b111; fwd_sel = {3'd3, 3'd5, 3'd3}; fwd_data = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    issue({3'd5, 3'd3}, 2'b11, 3'd4, 1'b1, 1'b0, {16'h2222, 16'h1111}, {16'hBBBB, 16'hAAAA}, 1, w);
    fwd_valid = 3'b110;
    issue({3'd5, 3'd3}, 2'b11, 3'd4, 1'b1, 1'b0, {16'h2222, 16'h1111}, {16'hBBBB, 16'hCCCC}, 1, w);
    fwd_valid = 3'b000;
    cycles(2);

    // Load-use on port 1: one hazard cycle, one bubble, then the tap value.
    issue({3'd0, 3'd0}, 2'b00, 3'd2, 1'b1, 1'b1, {16'h0202, 16'h0101}, {16'h0202, 16'h0101}, 1, w);
    fwd_valid = 3'b001; fwd_sel = {3'd0, 3'd0, 3'd2}; fwd_data = {16'h0, 16'h0, 16'h5A5A};
    src_sel = {3'd2, 3'd4}; src_used = 2'b10; dst_sel = 3'd5; dst_we = 1'b1; is_load = 1'b0;
    rf_rdata = {16'h0BAD, 16'h4444}; in_valid = 1'b1;
    @(negedge clk);
    chk("loaduse_in_ready", {in_ready}, {1'b0});
    @(posedge clk); #1;
    chk("loaduse_bubble", {out_valid}, {1'b0});
    chk("loaduse_stall_count", {stall_count}, {4'd1});
    issue({3'd2, 3'd4}, 2'b10, 3'd5, 1'b1, 1'b0, {16'h0BAD, 16'h4444}, {16'h5A5A, 16'h4444}, 1, w);
    chk("loaduse_waits", w, 64'd0);

    // Same pair with the dependent port unused: no stall.
    issue({3'd0, 3'd0}, 2'b00, 3'd2, 1'b1, 1'b1, {16'h0202, 16'h0101}, {16'h0202, 16'h0101}, 1, w);
    issue({3'd2, 3'd4}, 2'b01, 3'd5, 1'b1, 1'b0, {16'h0BAD, 16'h4444}, {16'h5A5A, 16'h4444}, 1, w);
    chk("unused_port_waits", w, 64'd0);
    chk("unused_port_stall_count", {stall_count}, {4'd1});
    cycles(2);

    // Backpressure while FULL: outputs frozen, shadow does not age.
    out_ready = 1'b0;
    issue({3'd0, 3'd0}, 2'b00, 3'd6, 1'b1, 1'b1, {16'h0606, 16'h6060}, {16'h0606, 16'h6060}, 1, w);
    hold = {16'h0606, 16'h6060};
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", {in_ready}, {1'b0});
      chk("bp_out_data", {out_data}, {hold});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue({3'd0, 3'd6}, 2'b01, 3'd3, 1'b1, 1'b0, {16'h0000, 16'h7777}, {16'h0000, 16'h7777}, 1, w);
    chk("bp_shadow_kept_waits", w, 64'd1);
    chk("bp_stall_count", {stall_count}, {4'd2});
    cycles(2);

    // Flush while the shadow is armed clears it and squashes the held load.
    issue({3'd0, 3'd0}, 2'b00, 3'd7, 1'b1, 1'b1, {16'h0707, 16'h7070}, '0, 0, w);
    flush = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", {in_ready}, {1'b0});
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", {out_valid}, {1'b0});
    issue({3'd0, 3'd7}, 2'b01, 3'd1, 1'b1, 1'b0, {16'h0000, 16'h1357}, {16'h0000, 16'h1357}, 1, w);
    chk("flush_waits", w, 64'd0);
    chk("flush_stall_count", {stall_count}, {4'd2});
    cycles(2);

    // Saturation: 20 hazard cycles against a held shadow, then reset mid-stall.
    fwd_valid = 3'b000;
    issue({3'd0, 3'd0}, 2'b00, 3'd1, 1'b1, 1'b1, {16'h0, 16'h0}, '0, 0, w);
    out_ready = 1'b0;
    src_sel = {3'd0, 3'd1}; src_used = 2'b01; dst_sel = 3'd2; dst_we = 1'b1; is_load = 1'b0;
    in_valid = 1'b1;
    cycles(20);
    chk("sat_stall_count", {stall_count}, {4'd15});
    chk("sat_in_ready", {in_ready}, {1'b0});
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst_out_valid", {out_valid}, {1'b0});
    chk("rst_out_fields", {out_data, out_dst_sel, out_dst_we, out_is_load}, {37'h0});
    chk("rst_stall_count", {stall_count}, {4'd0});
    @(negedge clk);
    chk("rst_shadow_cleared", {in_ready}, {1'b1});
    in_valid = 1'b0; src_used = 2'b00; out_ready = 1'b1;
    cycles(2);

    chk("queue_drained", q.size(), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/decode_fwd_hazard.md
# decode_fwd_hazard

Parametrised operand-resolution and hazard stage between instruction decode and execute. It takes register-file read data plus N downstream forwarding taps and picks the youngest matching value per read port. It tracks issued loads in an internal shadow counter and stalls dependent instructions, so execute needs no special memory-to-execute patch path. Results are held in a valid/ready decode/execute pipeline register, and hazard stall cycles are counted for performance monitoring.

## Interface
Parameters:
- DATA_W, 16, operand/data width
- NREGS, 8, architectural registers; REG_W = clog2(NREGS)
- NPORTS, 2, read ports
- NFWD, 3, forwarding taps; index 0 = youngest (execute), NFWD-1 = oldest (writeback)
- LOAD_LAT, 1, out_ready cycles after load issue during which its dst is unavailable (0 = no shadow)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous reset, active-low (reset when 0)
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready
- src_sel  in  NPORTS*REG_W  source register per port
- src_used  in  NPORTS  port p's operand is consumed
- dst_sel  in  REG_W  destination register
- dst_we  in  1  instruction writes dst_sel
- is_load  in  1  instruction is a memory load
- rf_rdata  in  NPORTS*DATA_W  register-file read data (write-through bypassed externally)
- fwd_valid  in  NFWD  tap k holds a result to be written
- fwd_sel  in  NFWD*REG_W  tap k destination register
- fwd_data  in  NFWD*DATA_W  tap k result
- flush  in  1  squash the pipeline register and load shadow
- out_valid  out  1  pipeline register holds an instruction
- out_ready  in  1  execute accepts the held instruction
- out_data  out  NPORTS*DATA_W  resolved operands
- out_dst_sel  out  REG_W  registered dst_sel
- out_dst_we  out  1  registered dst_we
- out_is_load  out  1  registered is_load
- stall_count  out  CNT_W  saturating count of hazard-stall cycles

## Operation
Operand select, per port p, combinational:
- The lowest k with fwd_valid[k] and fwd_sel[k]==src_sel[p] supplies fwd_data[k].
- If no tap matches, rf_rdata[p] is used.

Hazard:
- hazard = in_valid & shadow_cnt!=0 & OR over p of (src_used[p] & src_sel[p]==shadow_reg).
- Ports with src_used=0 never cause a hazard.

Ready and accept:
- in_ready = ~flush & ~hazard & (~out_valid | out_ready).
- On accept, the pipeline register loads the resolved operands and dst/we/load fields, and out_valid becomes 1.
- If the register drains (out_ready) with no accept, out_valid becomes 0. This inserts a bubble.

Out-register FSM:
- EMPTY→FULL on accept.
- FULL→FULL on accept with out_ready.
- FULL→EMPTY on out_ready without accept.
- FULL holds when out_ready=0; outputs stay stable.

Load shadow:
- On accept with is_load & dst_we & LOAD_LAT>0: shadow_cnt←LOAD_LAT and shadow_reg←dst_sel. This overwrites any older shadow.
- Otherwise shadow_cnt decrements by 1 on each cycle with out_ready=1 while nonzero.

stall_count:
- Increments on each cycle with hazard=1.
- Saturates at 2^CNT_W-1; it does not wrap.

flush:
- out_valid←0 and shadow_cnt←0.
- Any same-cycle instruction is not accepted (in_ready=0).
- stall_count is unaffected.

## Timing
- Latency: accept at edge n → out_* valid after edge n. One-cycle registered stage; no combinational in→out path except in_ready.
- in_ready depends combinationally on out_ready, flush, src_sel and src_used.
- Load followed by dependent instruction, LOAD_LAT=1, out_ready=1:
  - The dependent instruction is held exactly one cycle.
  - In that cycle execute receives a bubble.
  - The dependent instruction is then accepted; the load value arrives via the tap.
- Shadow versus taps: the shadow applies even when a tap matches, because tap data for a pending load is not yet valid.
- Reset (rst=0 at an edge), including mid-stall:
  - out_valid=0, out_data=0, out_dst_sel=0, out_dst_we=0, out_is_load=0.
  - shadow_cnt=0, shadow_reg=0, stall_count=0.
  - in_ready follows its equation after reset (1 if not flushing).
- Simultaneous flush and out_ready: flush wins and out_valid=0 next cycle.

## Structure
- Shared package decode_pkg holds:
  - the clog2-based REG_W helper;
  - default DATA_W and NREGS constants;
  - an out-register state enum {EMPTY, FULL}.
- Sub-module fwd_select is instantiated once per port, parametrised by DATA_W, REG_W and NFWD. It is a pure combinational priority mux.
- Top level holds hazard logic, pipeline register, shadow counter and stall counter.

## Test plan
- No-match read: src_sel={3,5}, rf_rdata={0x1111,0x2222}, no taps valid → out_data={0x1111,0x2222} one cycle after accept.
- Priority: taps 0 and 2 both target r3 with 0xAAAA and 0xCCCC, src_sel[0]=3 → out_data[0]=0xAAAA; deassert tap 0 → 0xCCCC.
- Load-use, LOAD_LAT=1: issue load to r2, then an instruction reading r2 on port 1:
  - one bubble (out_valid=0) in between;
  - stall_count=1;
  - then accept with tap value.
  - Repeat with src_used[1]=0: no stall.
- Backpressure: out_ready=0 for 4 cycles while FULL → out_* constant and in_ready=0; shadow_cnt does not decrement.
- Flush during shadow: flush with shadow_cnt=1 → next dependent instruction accepted without stall; out_valid=0 after flush edge.
- Reset and saturation, CNT_W=4:
  - force 20 hazard cycles → stall_count=15;
  - assert rst=0 mid-stall → all outputs 0 and stall_count=0 at the next edge.
